instr_loader: RTL and testbench
===============================

# instr_loader

Front-panel program entry for the 16-bit processor: assembles 16-bit instruction words from 4-bit switch nibbles, one nibble per debounced key strobe, and writes each completed word into instruction memory at an auto-incrementing 7-bit address through a valid/ready write handshake. It sits between the button synchroniser/filter path and the processor's instruction memory write port. It also exposes the partial word, nibble count and address for the hex displays.

## Interface
- DATA_W, 16, instruction word width; must be a multiple of NIB_W
- NIB_W, 4, nibble width; one switch group per strobe
- ADDR_W, 7, memory address width; matches the PC width
- CLOCK_50  in  1  system clock; all logic on the rising edge
- Reset  in  1  synchronous, active-high reset
- nib_in  in  NIB_W  nibble value from switches; sampled only on nib_stb
- nib_stb  in  1  single-cycle pulse (filtered key); shift nib_in into the word
- clr_stb  in  1  single-cycle pulse; discard the partial word
- wr_ready  in  1  memory accepts the write this cycle
- wr_valid  out  1  write request pending
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- word_view  out  DATA_W  partial or complete word, for the display
- nib_cnt  out  3  nibbles collected in the current word (0..4)
- full  out  1  last address written; loader locked

## Operation
- Three states: COLLECT, WRITE, FULL.
- COLLECT:
  - On nib_stb: word <= {word[DATA_W-NIB_W-1:0], nib_in} and nib_cnt increments. The first nibble entered ends up in word[15:12].
  - When the strobe brings nib_cnt to DATA_W/NIB_W (4), the state goes to WRITE.
- WRITE:
  - wr_valid = 1. wr_addr and wr_data stay constant until the handshake completes.
  - Handshake completes on the cycle where wr_valid & wr_ready. On the next cycle: word = 0, nib_cnt = 0.
  - If wr_addr was 2^ADDR_W-1, the state goes to FULL and wr_addr holds at 127. Otherwise wr_addr increments and the state returns to COLLECT.
- FULL: nib_stb and clr_stb are ignored. full = 1. Only Reset leaves this state.
- clr_stb in COLLECT: word = 0 and nib_cnt = 0. Address is unchanged.
- Strobes in WRITE: nib_stb and clr_stb are both ignored. A write request is never cancelled once raised.
- nib_stb and clr_stb in the same cycle: clr_stb wins and the nibble is dropped.
- wr_ready while wr_valid = 0 has no effect.
- word_view = word register. wr_data = word register, valid only while wr_valid.
- No wrap-around: address 127 is written exactly once, then the loader locks.

## Timing
- Reset values: state COLLECT, word 0, nib_cnt 0, wr_addr 0, wr_valid 0, full 0.
- Reset is synchronous. When asserted mid-WRITE, wr_valid is 0 on the cycle after the reset edge, and the pending word is lost.
- The 4th nib_stb is sampled at edge N. wr_valid = 1 from edge N (registered output). No combinational path from nib_stb to wr_valid.
- A handshake at edge M gives wr_valid = 0, the incremented wr_addr and nib_cnt = 0 after edge M.
- A nib_stb at edge M+1 is accepted as the first nibble of the next word.
- Back-to-back words need at least 5 cycles each: 4 strobes plus 1 handshake cycle minimum.
- All outputs are registered. wr_ready is the only input that reaches an output-affecting decision within a cycle, and it only does so through next-state logic.

## Structure
- Shared package:
  - loader state enum {COLLECT, WRITE, FULL}
  - DATA_W / NIB_W / ADDR_W defaults
  - NIBS_PER_WORD = DATA_W/NIB_W
- One optional sub-module, nibble_shifter: word register and nib_cnt, with load/clear enables.
- The FSM and address counter stay in instr_loader.
- Strobes arrive already synchronised and filtered by the existing button path. No debouncing inside this block.

## Test plan
- Reset, then nib_in = 1,2,3,4 on four separate nib_stb with wr_ready = 1 -> wr_valid pulses for one cycle with wr_addr 0x00 and wr_data 0x1234; afterwards wr_addr 0x01 and nib_cnt 0.
- Nibbles A,B,C,D with wr_ready held 0 for 10 cycles -> wr_valid, wr_addr and wr_data 0xABCD stay stable for all 10 cycles; nib_stb with nib_in = F during the stall does not change word_view; raising wr_ready completes a single write.
- Nibbles 5,6, then clr_stb, then 7,8,9,0 -> exactly one write, data 0x7890.
- nib_stb and clr_stb in the same cycle after 2 nibbles -> nib_cnt 0, word_view 0.
- Write 128 words with data equal to the index -> last write is addr 0x7F, data 0x007F; then full = 1; further nib_stb leaves nib_cnt at 0 and wr_valid at 0.
- Reset asserted during a stalled WRITE (wr_ready = 0) -> next cycle wr_valid = 0, wr_addr 0, full 0, word_view 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared widths, derived constants and loader state type for the
// front-panel instruction loader.
package instr_loader_pkg;
  localparam int DATA_W        = 16;
  localparam int NIB_W         = 4;
  localparam int ADDR_W        = 7;
  localparam int NIBS_PER_WORD = DATA_W / NIB_W;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    FULL    = 2'd2
  } state_e;
endpackage

// File: rtl/instr_loader_if.sv
// Instruction-memory write port: valid/ready handshake with address and data.
interface instr_loader_if #(
  parameter int DW = instr_loader_pkg::DATA_W,
  parameter int AW = instr_loader_pkg::ADDR_W
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/instr_loader_nibble_shifter.sv
// Word assembly register: shifts one nibble in at the LSB end per load and
// counts nibbles; clear takes priority over load.
module instr_loader_nibble_shifter #(
  parameter int DATA_W = instr_loader_pkg::DATA_W,
  parameter int NIB_W  = instr_loader_pkg::NIB_W,
  parameter int CNT_W  = instr_loader_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [NIB_W-1:0]  nib,
  output logic [DATA_W-1:0] word,
  output logic [CNT_W-1:0]  cnt
);
  logic [DATA_W-1:0] word_d, word_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      word_d = {word_q[DATA_W-NIB_W-1:0], nib};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word = word_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/instr_loader.sv
// Front-panel program entry: builds instruction words from key-strobed
// nibbles and writes them to sequential addresses, locking after the last one.
module instr_loader #(
  parameter int DATA_W = instr_loader_pkg::DATA_W,
  parameter int NIB_W  = instr_loader_pkg::NIB_W,
  parameter int ADDR_W = instr_loader_pkg::ADDR_W
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [NIB_W-1:0]  nib_in,
  input  logic              nib_stb,
  input  logic              clr_stb,
  instr_loader_if.master    wr,
  output logic [DATA_W-1:0] word_view,
  output logic [2:0]        nib_cnt,
  output logic              full
);
  import instr_loader_pkg::*;

  localparam int              NPW      = DATA_W / NIB_W;
  localparam logic [2:0]      LAST_CNT = 3'(NPW - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              sh_load, sh_clr;
  logic [DATA_W-1:0] word;
  logic [2:0]        cnt;

  instr_loader_nibble_shifter #(
    .DATA_W(DATA_W), .NIB_W(NIB_W), .CNT_W(3)
  ) u_shift (
    .clk (CLOCK_50),
    .rst (Reset),
    .load(sh_load),
    .clr (sh_clr),
    .nib (nib_in),
    .word(word),
    .cnt (cnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sh_load = 1'b0;
    sh_clr  = 1'b0;
    case (state_q)
      COLLECT: begin
        // clear beats a simultaneous nibble strobe
        if (clr_stb) begin
          sh_clr = 1'b1;
        end else if (nib_stb) begin
          sh_load = 1'b1;
          if (cnt == LAST_CNT) state_d = WRITE;
        end
      end
      WRITE: begin
        if (wr.wr_ready) begin
          sh_clr = 1'b1;
          if (addr_q == ADDR_MAX) begin
            state_d = FULL;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = COLLECT;
          end
        end
      end
      FULL:    state_d = FULL;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= COLLECT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign wr.wr_valid = (state_q == WRITE);
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = word;
  assign word_view   = word;
  assign nib_cnt     = cnt;
  assign full        = (state_q == FULL);
endmodule

// File: tb/tb_instr_loader.sv
// Randomized and directed bench for instr_loader against a behavioural
// word/address model; DUT writes are logged from the observed handshake.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  nib_in;
  logic        nib_stb;
  logic        clr_stb;
  logic [15:0] word_view;
  logic [2:0]  nib_cnt;
  logic        full;

  instr_loader_if wb ();

  always #10 clk = ~clk;

  instr_loader dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .nib_in   (nib_in),
    .nib_stb  (nib_stb),
    .clr_stb  (clr_stb),
    .wr       (wb.master),
    .word_view(word_view),
    .nib_cnt  (nib_cnt),
    .full     (full)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // behavioural model: word as an integer, a pending flag and an address
  int m_word, m_cnt, m_addr;
  bit m_pend, m_full;

  typedef struct { int addr; int data; } wr_t;
  wr_t dut_log[$];

  function automatic void model(input int n, input bit ns, input bit cs, input bit rdy, input bit r);
    if (r) begin
      m_word = 0; m_cnt = 0; m_addr = 0; m_pend = 0; m_full = 0;
    end else if (m_full) begin
    end else if (m_pend) begin
      if (rdy) begin
        m_word = 0; m_cnt = 0; m_pend = 0;
        if (m_addr == 127) m_full = 1;
        else m_addr = m_addr + 1;
      end
    end else if (cs) begin
      m_word = 0; m_cnt = 0;
    end else if (ns) begin
      m_word = ((m_word * 16) + n) % 65536;
      m_cnt  = m_cnt + 1;
      if (m_cnt == 4) m_pend = 1;
    end
  endfunction

  task automatic step(input logic [3:0] n, input logic ns, input logic cs, input logic rdy, input logic r);
    nib_in = n; nib_stb = ns; clr_stb = cs; wb.wr_ready = rdy; rst = r;
    #1;
    if (!r && wb.wr_valid === 1'b1 && rdy)
      dut_log.push_back('{int'(wb.wr_addr), int'(wb.wr_data)});
    @(posedge clk);
    model(int'(n), ns, cs, rdy, r);
    #1;
    chk("valid", 32'(wb.wr_valid), 32'(m_pend));
    chk("addr",  32'(wb.wr_addr),  32'(m_addr));
    chk("view",  32'(word_view),   32'(m_word));
    chk("cnt",   32'(nib_cnt),     32'(m_cnt));
    chk("full",  32'(full),        32'(m_full));
    if (m_pend) chk("data", 32'(wb.wr_data), 32'(m_word));
  endtask

  task automatic nib(input logic [3:0] n, input logic rdy);
    step(n, 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(4'h0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    nib_in = '0; nib_stb = 0; clr_stb = 0; wb.wr_ready = 0; rst = 1;
    do_reset();
    chk("rst_valid", 32'(wb.wr_valid), 32'h0);
    chk("rst_addr",  32'(wb.wr_addr),  32'h0);
    chk("rst_full",  32'(full),        32'h0);
    chk("rst_cnt",   32'(nib_cnt),     32'h0);

    // single word with memory always ready
    dut_log.delete();
    nib(4'h1, 1); nib(4'h2, 1); nib(4'h3, 1); nib(4'h4, 1);
    chk("t1_valid", 32'(wb.wr_valid), 32'h1);
    chk("t1_data",  32'(wb.wr_data),  32'h1234);
    idle(1);
    chk("t1_valid_drop", 32'(wb.wr_valid), 32'h0);
    chk("t1_addr_inc",   32'(wb.wr_addr),  32'h1);
    idle(1);
    chk("t1_nwr", 32'(dut_log.size()), 32'h1);
    if (dut_log.size() > 0) begin
      chk("t1_waddr", 32'(dut_log[0].addr), 32'h0);
      chk("t1_wdata", 32'(dut_log[0].data), 32'h1234);
    end

    // stalled write; nibble during the stall must be ignored
    dut_log.delete();
    nib(4'hA, 0); nib(4'hB, 0); nib(4'hC, 0); nib(4'hD, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) nib(4'hF, 0);
      else idle(0);
      chk("t2_stall_data", 32'(wb.wr_data), 32'hABCD);
      chk("t2_stall_addr", 32'(wb.wr_addr), 32'h1);
    end
    chk("t2_view", 32'(word_view), 32'hABCD);
    idle(1); idle(1); idle(1);
    chk("t2_nwr", 32'(dut_log.size()), 32'h1);
    if (dut_log.size() > 0) chk("t2_wdata", 32'(dut_log[0].data), 32'hABCD);

    // clear discards the partial word
    dut_log.delete();
    nib(4'h5, 1); nib(4'h6, 1);
    step(4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    nib(4'h7, 1); nib(4'h8, 1); nib(4'h9, 1); nib(4'h0, 1);
    idle(1); idle(1);
    chk("t3_nwr", 32'(dut_log.size()), 32'h1);
    if (dut_log.size() > 0) begin
      chk("t3_wdata", 32'(dut_log[0].data), 32'h7890);
      chk("t3_waddr", 32'(dut_log[0].addr), 32'h2);
    end

    // simultaneous strobes: clear wins
    nib(4'h1, 0); nib(4'h2, 0);
    step(4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_cnt",  32'(nib_cnt),   32'h0);
    chk("t4_view", 32'(word_view), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0), 1'b0);

    // fill all 128 addresses, then lock
    do_reset();
    dut_log.delete();
    for (int w = 0; w < 128; w++) begin
      logic [15:0] v;
      v = 16'(w);
      nib(v[15:12], 1); nib(v[11:8], 1); nib(v[7:4], 1); nib(v[3:0], 1);
      idle(1);
    end
    chk("t6_nwr",  32'(dut_log.size()), 32'd128);
    if (dut_log.size() == 128) begin
      chk("t6_last_addr", 32'(dut_log[127].addr), 32'h7F);
      chk("t6_last_data", 32'(dut_log[127].data), 32'h007F);
      chk("t6_mid_data",  32'(dut_log[77].data),  32'd77);
    end
    chk("t6_full", 32'(full), 32'h1);
    nib(4'h3, 1); nib(4'h4, 1); step(4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_lock_cnt",   32'(nib_cnt),     32'h0);
    chk("t6_lock_valid", 32'(wb.wr_valid), 32'h0);
    chk("t6_lock_addr",  32'(wb.wr_addr),  32'h7F);

    // reset during a stalled write
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(0);
    nib(4'h1, 0); nib(4'h2, 0); nib(4'h3, 0); nib(4'h4, 0);
    idle(0); idle(0);
    chk("t7_pre_valid", 32'(wb.wr_valid), 32'h1);
    step(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t7_valid", 32'(wb.wr_valid), 32'h0);
    chk("t7_addr",  32'(wb.wr_addr),  32'h0);
    chk("t7_full",  32'(full),        32'h0);
    chk("t7_view",  32'(word_view),   32'h0);
    idle(1); idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
